pixel_window: RTL

Streaming 3x3 window generator that feeds the intensity stage. It accepts one raster-order 24-bit RGB pixel per handshake and keeps two line buffers. For every interior pixel position it emits a registered 216-bit 3x3 neighbourhood (`pixelData`) in exactly the packing the intensity block consumes. It is the producer end of the `pixelData` interface.

---
 rtl/pixel_window.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pixel_window.sv
// pixel_window: streaming 3x3 window generator for the intensity stage.
// Accepts raster-order 24-bit {R,G,B} pixels, keeps two line buffers and
// emits a registered 216-bit 3x3 neighbourhood for every interior pixel.
// Window packing: pixel k (row-major, k=0 top-left) at [215-24k -: 24].
// Optional feature: define PIXEL_WINDOW_COORD_EN to add the win_x/win_y
// outputs carrying the window centre, registered alongside pixelData.

module pixel_window #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [23:0]                   pixel_in,
    input  logic                          in_valid,
    input  logic                          in_sof,
    output logic                          in_ready,
    output logic [215:0]                  pixelData,
    output logic                          window_valid,
    input  logic                          window_ready
`ifdef PIXEL_WINDOW_COORD_EN
    ,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_y
`endif
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    // Position of the next pixel to be accepted
    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;

    // lb0 holds row y-1, lb1 holds row y-2 (not reset)
    logic [23:0] lb0_q [IMG_WIDTH];
    logic [23:0] lb1_q [IMG_WIDTH];

    // Left and middle window columns, each {top, mid, bottom}; the right
    // column arrives with the accepted pixel, so it is never stored here.
    logic [71:0] col_l_q, col_l_d;
    logic [71:0] col_m_q, col_m_d;

    // Output register
    logic [215:0] pixel_data_q, pixel_data_d;
    logic         window_valid_q, window_valid_d;
`ifdef PIXEL_WINDOW_COORD_EN
    logic [XW-1:0] win_x_q, win_x_d;
    logic [YW-1:0] win_y_q, win_y_d;
`endif

    logic          accept;
    logic          emit;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic [23:0]   lb0_rd;
    logic [23:0]   lb1_rd;
    logic [71:0]   col_new;
    logic [215:0]  win_data;

    // Handshake, effective position (sof forces (0,0)) and window assembly
    always_comb begin
        in_ready = !window_valid_q || window_ready;
        accept   = in_valid && in_ready;
        pos_x    = in_sof ? '0 : col_q;
        pos_y    = in_sof ? '0 : row_q;
        lb0_rd   = lb0_q[pos_x];
        lb1_rd   = lb1_q[pos_x];
        col_new  = {lb1_rd, lb0_rd, pixel_in};
        emit     = accept && (pos_x >= X_TWO) && (pos_y >= Y_TWO);
        win_data = {col_l_q[71:48], col_m_q[71:48], col_new[71:48],
                    col_l_q[47:24], col_m_q[47:24], col_new[47:24],
                    col_l_q[23:0],  col_m_q[23:0],  col_new[23:0]};
    end

    // Next-state for raster counters and the column shift register
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        col_l_d = col_l_q;
        col_m_d = col_m_q;
        if (accept) begin
            col_l_d = col_m_q;
            col_m_d = col_new;
            if (pos_x == X_LAST) begin
                col_d = '0;
                row_d = (pos_y == Y_LAST) ? '0 : pos_y + YW'(1);
            end else begin
                col_d = pos_x + XW'(1);
                row_d = pos_y;
            end
        end
    end

    // Next-state for the output register; a consume and a load in the
    // same cycle leave window_valid set with the new window.
    always_comb begin
        pixel_data_d   = emit ? win_data : pixel_data_q;
        window_valid_d = emit || (window_valid_q && !window_ready);
`ifdef PIXEL_WINDOW_COORD_EN
        win_x_d = emit ? pos_x - XW'(1) : win_x_q;
        win_y_d = emit ? pos_y - YW'(1) : win_y_q;
`endif
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_q          <= '0;
            row_q          <= '0;
            col_l_q        <= '0;
            col_m_q        <= '0;
            pixel_data_q   <= '0;
            window_valid_q <= 1'b0;
`ifdef PIXEL_WINDOW_COORD_EN
            win_x_q        <= '0;
            win_y_q        <= '0;
`endif
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            col_l_q        <= col_l_d;
            col_m_q        <= col_m_d;
            pixel_data_q   <= pixel_data_d;
            window_valid_q <= window_valid_d;
`ifdef PIXEL_WINDOW_COORD_EN
            win_x_q        <= win_x_d;
            win_y_q        <= win_y_d;
`endif
        end
    end

    // Line buffer update: the row above moves down, the new pixel goes in
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[pos_x] <= lb0_q[pos_x];
            lb0_q[pos_x] <= pixel_in;
        end
    end

    assign pixelData    = pixel_data_q;
    assign window_valid = window_valid_q;
`ifdef PIXEL_WINDOW_COORD_EN
    assign win_x        = win_x_q;
    assign win_y        = win_y_q;
`endif

endmodule
